// File: rtl/cn_aes256_key_expand.sv
// Iterative AES-256 key schedule for CryptoNight: produces round keys rk0..rk9,
// one 128-bit key per cycle, using a single external 32-bit S-box lookup.
module cn_aes256_key_expand #(
    parameter int NUM_RK = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] key,
    output logic         ready,
    output logic         valid,
    output logic         done,
    input  logic [3:0]   rk_addr,
    output logic [127:0] rk_data,
    output logic [31:0]  sboxw,
    input  logic [31:0]  new_sboxw
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        GEN  = 1'b1
    } state_t;

    state_t         state_r;
    state_t         state_nxt_s;
    logic [3:0]     cnt_r;
    logic [127:0]   rk_r [NUM_RK];
    logic           ready_r;
    logic           valid_r;
    logic           done_r;
    logic [127:0]   rk_data_r;
    logic [31:0]    sboxw_r;

    logic           accept_s;
    logic           gen_s;
    logic           last_s;
    logic [127:0]   p2_s;
    logic [7:0]     rcon_s;
    logic [31:0]    t_s;
    logic [31:0]    n0_s;
    logic [31:0]    n1_s;
    logic [31:0]    n2_s;
    logic [31:0]    n3_s;
    logic [127:0]   new_rk_s;
    logic [127:0]   rd_s;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start && ready_r) begin
                    state_nxt_s = GEN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            GEN: begin
                if (cnt_r == 4'd9) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = GEN;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM control decode
    always_comb begin
        accept_s = 1'b0;
        gen_s    = 1'b0;
        last_s   = 1'b0;
        case (state_r)
            IDLE: accept_s = start & ready_r;
            GEN: begin
                gen_s  = 1'b1;
                last_s = (cnt_r == 4'd9);
            end
            default: begin
                accept_s = 1'b0;
                gen_s    = 1'b0;
                last_s   = 1'b0;
            end
        endcase
    end

    // Previous-previous round key rk[i-2] for the current round index
    always_comb begin
        case (cnt_r)
            4'd2:    p2_s = rk_r[0];
            4'd3:    p2_s = rk_r[1];
            4'd4:    p2_s = rk_r[2];
            4'd5:    p2_s = rk_r[3];
            4'd6:    p2_s = rk_r[4];
            4'd7:    p2_s = rk_r[5];
            4'd8:    p2_s = rk_r[6];
            4'd9:    p2_s = rk_r[7];
            default: p2_s = 128'h0;
        endcase
    end

    // Next round key; even rounds rotate the S-box word and add rcon
    always_comb begin
        rcon_s = 8'h01 << (cnt_r[3:1] - 3'd1);
        if (cnt_r[0] == 1'b0) begin
            t_s = {new_sboxw[23:0], new_sboxw[31:24]} ^ {rcon_s, 24'h000000};
        end else begin
            t_s = new_sboxw;
        end
        n0_s     = p2_s[127:96] ^ t_s;
        n1_s     = p2_s[95:64]  ^ n0_s;
        n2_s     = p2_s[63:32]  ^ n1_s;
        n3_s     = p2_s[31:0]   ^ n2_s;
        new_rk_s = {n0_s, n1_s, n2_s, n3_s};
    end

    // Read port mux; out-of-range addresses read as zero
    always_comb begin
        case (rk_addr)
            4'd0:    rd_s = rk_r[0];
            4'd1:    rd_s = rk_r[1];
            4'd2:    rd_s = rk_r[2];
            4'd3:    rd_s = rk_r[3];
            4'd4:    rd_s = rk_r[4];
            4'd5:    rd_s = rk_r[5];
            4'd6:    rd_s = rk_r[6];
            4'd7:    rd_s = rk_r[7];
            4'd8:    rd_s = rk_r[8];
            4'd9:    rd_s = rk_r[9];
            default: rd_s = 128'h0;
        endcase
    end

    // Datapath: key load, per-round write, handshake flags and S-box word
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_RK; k++) begin
                rk_r[k] <= 128'h0;
            end
            cnt_r     <= 4'd0;
            ready_r   <= 1'b1;
            valid_r   <= 1'b0;
            done_r    <= 1'b0;
            sboxw_r   <= 32'h0;
            rk_data_r <= 128'h0;
        end else begin
            rk_data_r <= rd_s;
            done_r    <= 1'b0;
            if (accept_s) begin
                rk_r[0] <= key[255:128];
                rk_r[1] <= key[127:0];
                cnt_r   <= 4'd2;
                ready_r <= 1'b0;
                valid_r <= 1'b0;
                sboxw_r <= key[31:0];
            end else if (gen_s) begin
                for (int k = 2; k < NUM_RK; k++) begin
                    if (cnt_r == k[3:0]) begin
                        rk_r[k] <= new_rk_s;
                    end
                end
                // The word just produced feeds the S-box for the following round
                if (last_s) begin
                    cnt_r   <= 4'd0;
                    ready_r <= 1'b1;
                    valid_r <= 1'b1;
                    done_r  <= 1'b1;
                    sboxw_r <= 32'h0;
                end else begin
                    cnt_r   <= cnt_r + 4'd1;
                    sboxw_r <= n3_s;
                end
            end
        end
    end

    assign ready   = ready_r;
    assign valid   = valid_r;
    assign done    = done_r;
    assign rk_data = rk_data_r;
    assign sboxw   = sboxw_r;

endmodule

// File: tb/tb_cn_aes256_key_expand.sv
// Directed bench for cn_aes256_key_expand with a table-based S-box model
// standing in for aes_sbox.
module tb_cn_aes256_key_expand;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    localparam logic [255:0] KEY_Z = 256'h0;
    localparam logic [255:0] KEY_F = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [255:0] key = 256'h0;
    logic         ready;
    logic         valid;
    logic         done;
    logic [3:0]   rk_addr = 4'd0;
    logic [127:0] rk_data;
    logic [31:0]  sboxw;
    logic [31:0]  new_sboxw;

    int checks = 0;
    int errors = 0;
    logic [127:0] fips_rk [10];

    cn_aes256_key_expand dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key       (key),
        .ready     (ready),
        .valid     (valid),
        .done      (done),
        .rk_addr   (rk_addr),
        .rk_data   (rk_data),
        .sboxw     (sboxw),
        .new_sboxw (new_sboxw)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] sb(input logic [7:0] b);
        return SBOX[(255 - int'(b)) * 8 +: 8];
    endfunction

    assign new_sboxw = {sb(sboxw[31:24]), sb(sboxw[23:16]), sb(sboxw[15:8]), sb(sboxw[7:0])};

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_check(input string tag, input logic [3:0] addr, input logic [127:0] exp);
        rk_addr = addr;
        tick();
        check(tag, rk_data, exp);
    endtask

    // Wait (bounded) for done; returns number of edges waited
    task automatic wait_done(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!done && n < 20);
    endtask

    task automatic expand(input string tag, input logic [255:0] k);
        int n;
        key   = k;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy"}, {127'h0, ready}, 128'h0);
        wait_done(n);
        check({tag, "_lat"}, 128'(n), 128'd8);
        check({tag, "_flags"}, {125'h0, ready, valid, done}, 128'h7);
        tick();
        check({tag, "_done_pulse"}, {127'h0, done}, 128'h0);
    endtask

    initial begin
        int n;
        int dones;
        fips_rk[0] = 128'h000102030405060708090a0b0c0d0e0f;
        fips_rk[1] = 128'h101112131415161718191a1b1c1d1e1f;
        fips_rk[2] = 128'ha573c29fa176c498a97fce93a572c09c;
        fips_rk[3] = 128'h1651a8cd0244beda1a5da4c10640bade;
        fips_rk[4] = 128'hae87dff00ff11b68a68ed5fb03fc1567;
        fips_rk[5] = 128'h6de1f1486fa54f9275f8eb5373b8518d;
        fips_rk[6] = 128'hc656827fc9a799176f294cec6cd5598b;
        fips_rk[7] = 128'h3de23a75524775e727bf9eb45407cf39;
        fips_rk[8] = 128'h0bdc905fc27b0948ad5245a4c1871c2f;
        fips_rk[9] = 128'h45f5a66017b2d387300d4d33640a820a;

        tick();
        tick();
        rst = 1'b0;
        check("rst_flags", {125'h0, ready, valid, done}, 128'h4);
        check("rst_sboxw", {96'h0, sboxw}, 128'h0);
        check("rst_rkdata", rk_data, 128'h0);

        // T1: all-zero key
        expand("t1", KEY_Z);
        rd_check("t1_rk2", 4'd2, 128'h62636363626363636263636362636363);
        rd_check("t1_rk3", 4'd3, 128'haafbfbfbaafbfbfbaafbfbfbaafbfbfb);
        rd_check("t1_rk4", 4'd4, 128'h6f6c6ccf0d0f0fac6f6c6ccf0d0f0fac);
        rd_check("t1_rk5", 4'd5, 128'h7d8d8d6ad77676917d8d8d6ad7767691);
        check("t1_sboxw_idle", {96'h0, sboxw}, 128'h0);

        // T2: FIPS-197 AES-256 key, including the S-box word of the first two rounds
        key   = KEY_F;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t2_sboxw_r2", {96'h0, sboxw}, 128'h1c1d1e1f);
        tick();
        check("t2_sboxw_r3", {96'h0, sboxw}, 128'ha572c09c);
        wait_done(n);
        check("t2_lat", 128'(n), 128'd7);
        for (int i = 0; i < 10; i++) begin
            rd_check($sformatf("t2_rk%0d", i), 4'(i), fips_rk[i]);
        end
        rd_check("t2_addr15", 4'd15, 128'h0);
        rd_check("t2_addr10", 4'd10, 128'h0);

        // T4: start pulses during expansion are ignored
        key   = KEY_Z;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        key   = KEY_F;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(n);
        check("t4_lat", 128'(n), 128'd3);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) dones++;
        end
        check("t4_single_done", 128'(dones), 128'd0);
        rd_check("t4_rk2", 4'd2, 128'h62636363626363636263636362636363);
        rd_check("t4_rk5", 4'd5, 128'h7d8d8d6ad77676917d8d8d6ad7767691);

        // T5: reset in the middle of an expansion
        key   = KEY_F;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_flags", {125'h0, ready, valid, done}, 128'h4);
        check("t5_sboxw", {96'h0, sboxw}, 128'h0);
        for (int i = 0; i < 10; i++) begin
            rd_check($sformatf("t5_rk%0d_clr", i), 4'(i), 128'h0);
        end
        expand("t5_again", KEY_F);
        rd_check("t5_rk9", 4'd9, fips_rk[9]);

        // T6: start held high; second expansion starts the edge after ready rises
        key   = KEY_Z;
        start = 1'b1;
        tick();
        key = KEY_F;
        wait_done(n);
        check("t6_lat1", 128'(n), 128'd8);
        tick();
        check("t6_reaccept", {126'h0, ready, valid}, 128'h0);
        for (int i = 0; i < 7; i++) tick();
        check("t6_valid_low_e7", {127'h0, valid}, 128'h0);
        tick();
        check("t6_valid_e8", {126'h0, valid, done}, 128'h3);
        start = 1'b0;
        rd_check("t6_rk9", 4'd9, fips_rk[9]);
        rd_check("t6_rk3", 4'd3, fips_rk[3]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
